// File: rtl/clb_gen.sv
// Configurable logic block generator: NCELL LUT_K-input cells with a registered
// output each, programmed through a serial configuration shift register.
module clb_gen #(
  parameter int LUT_K = 4,
  parameter int NCELL = 2
) (
  input  logic                     K,
  input  logic                     RN,
  input  logic                     CFG_CLR,
  input  logic                     CFG_EN,
  input  logic                     CFG_DIN,
  output logic                     CFG_DONE,
  input  logic [NCELL*LUT_K-1:0]   IN,
  input  logic [NCELL-1:0]         CE,
  input  logic [NCELL-1:0]         SR,
  output logic [NCELL-1:0]         X,
  output logic [NCELL-1:0]         Q
);

  localparam int NLUT     = 1 << LUT_K;
  localparam int CB       = NLUT + 4;
  localparam int CFG_LEN  = NCELL * CB;
  localparam int CW       = $clog2(CFG_LEN + 1);
  // Bit offsets of the control fields inside one cell's config field.
  localparam int OUTSEL_B = NLUT;
  localparam int FBSEL_B  = NLUT + 1;
  localparam int SRVAL_B  = NLUT + 2;
  localparam int INIT_B   = NLUT + 3;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CFG_LEN-1:0]   cfg_q, cfg_d;
  logic [NCELL-1:0]     q_q, q_d;
  logic [NCELL-1:0]     f;
  logic                 accept;
  logic                 enter;
  logic                 active;

  // A config bit is taken only while not yet configured; clear wins over enable.
  assign accept = CFG_EN && !CFG_CLR && (state_q != ACTIVE);
  // The bit that completes the stream moves us to ACTIVE on this very edge.
  assign enter  = (state_q == LOAD) && accept && (cnt_q == CW'(CFG_LEN - 1));

  // State, bit counter and config store; reset discards any configuration.
  always_ff @(posedge K or negedge RN) begin
    if (!RN) begin
      state_q <= UNCONF;
      cnt_q   <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
    end
  end

  // Next state: serial shift (first bit lands at bit 0), counting and clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    if (accept) begin
      cfg_d = {CFG_DIN, cfg_q[CFG_LEN-1:1]};
    end
    if (CFG_CLR) begin
      state_d = UNCONF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        UNCONF: begin
          if (CFG_EN) begin
            state_d = LOAD;
            cnt_d   = CW'(1);
          end
        end
        LOAD: begin
          if (CFG_EN) begin
            cnt_d = cnt_q + 1'b1;
            if (enter) begin
              state_d = ACTIVE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // FSM outputs decode only the registered state, so CFG_DONE has no input path.
  always_comb begin
    active   = (state_q == ACTIVE);
    CFG_DONE = active;
  end

  // Cell register next values: INIT on entry (using the just-completed config),
  // then SR over CE over hold; forced to zero whenever not ACTIVE.
  always_comb begin
    q_d = '0;
    for (int i = 0; i < NCELL; i++) begin
      if (CFG_CLR) begin
        q_d[i] = 1'b0;
      end else if (enter) begin
        q_d[i] = cfg_d[i*CB + INIT_B];
      end else if (active) begin
        if (SR[i]) begin
          q_d[i] = cfg_q[i*CB + SRVAL_B];
        end else if (CE[i]) begin
          q_d[i] = f[i];
        end else begin
          q_d[i] = q_q[i];
        end
      end else begin
        q_d[i] = 1'b0;
      end
    end
  end

  // Cell output registers.
  always_ff @(posedge K or negedge RN) begin
    if (!RN) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Per-cell LUT lookup and output mux; each cell only sees its own field/inputs.
  for (genvar gi = 0; gi < NCELL; gi++) begin : g_cell
    logic [NLUT-1:0]  lut;
    logic [LUT_K-1:0] addr;
    logic             fb_bit;

    assign lut    = cfg_q[gi*CB +: NLUT];
    assign fb_bit = cfg_q[gi*CB + FBSEL_B] ? q_q[gi] : IN[gi*LUT_K];
    assign addr   = {IN[gi*LUT_K + 1 +: LUT_K - 1], fb_bit};
    assign f[gi]  = lut[addr];
    assign X[gi]  = active & (cfg_q[gi*CB + OUTSEL_B] ? q_q[gi] : f[gi]);
  end

  assign Q = q_q;

endmodule

// File: tb/tb_clb_gen.sv
// Directed scoreboard bench for clb_gen (LUT_K=4, NCELL=2, 40 config bits).
// Observed word is {CFG_DONE, X[1:0], Q[1:0]}.
module tb_clb_gen;

  logic       K = 1'b0;
  logic       RN;
  logic       CFG_CLR;
  logic       CFG_EN;
  logic       CFG_DIN;
  logic       CFG_DONE;
  logic [7:0] IN;
  logic [1:0] CE;
  logic [1:0] SR;
  logic [1:0] X;
  logic [1:0] Q;

  int checks   = 0;
  int failures = 0;

  logic [4:0] exp_q[$];
  string      tag_q[$];

  logic [39:0] cfg_a;
  logic [39:0] cfg_b;

  always #5 K = ~K;

  clb_gen dut (
    .K        (K),
    .RN       (RN),
    .CFG_CLR  (CFG_CLR),
    .CFG_EN   (CFG_EN),
    .CFG_DIN  (CFG_DIN),
    .CFG_DONE (CFG_DONE),
    .IN       (IN),
    .CE       (CE),
    .SR       (SR),
    .X        (X),
    .Q        (Q)
  );

  function automatic logic [19:0] mk_cell(input logic [15:0] lut, input logic outsel,
                                          input logic fbsel, input logic srval,
                                          input logic init);
    return {init, srval, fbsel, outsel, lut};
  endfunction

  task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %-12s got=%b want=%b t=%0t", tag, got, want, $time);
    end else begin
      $display("ok   %-12s got=%b t=%0t", tag, got, $time);
    end
  endtask

  task automatic push_exp(input string tag, input logic [4:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    logic [4:0] e;
    string      t;
    if (exp_q.size() == 0) begin
      check_val("sb_underflow", {CFG_DONE, X, Q}, 5'bxxxxx);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, {CFG_DONE, X, Q}, e);
    end
  endtask

  // Expectation for the state after the next rising edge.
  task automatic step_expect(input string tag, input logic [4:0] e);
    push_exp(tag, e);
    @(posedge K);
    #1;
    pop_check();
  endtask

  // Expectation for combinational settling, no clock edge.
  task automatic now_expect(input string tag, input logic [4:0] e);
    push_exp(tag, e);
    #1;
    pop_check();
  endtask

  // Shift n bits of cfg, bit 0 first; check the last two accepted edges.
  task automatic send_cfg(input logic [39:0] cfg, input int n, input logic [4:0] last);
    for (int j = 0; j < n; j++) begin
      CFG_EN  = 1'b1;
      CFG_DIN = cfg[j];
      if (j == n - 2) begin
        step_expect("load_pre", 5'b00000);
      end else if (j == n - 1) begin
        step_expect("load_last", last);
      end else begin
        @(posedge K);
        #1;
      end
    end
    CFG_EN  = 1'b0;
    CFG_DIN = 1'b0;
  endtask

  initial begin
    RN = 1'b0; CFG_CLR = 1'b0; CFG_EN = 1'b0; CFG_DIN = 1'b0;
    IN = 8'h00; CE = 2'b00; SR = 2'b00;
    cfg_a = {20'h0, mk_cell(16'h0116, 1'b0, 1'b0, 1'b0, 1'b0)};
    cfg_b = {mk_cell(16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0),
             mk_cell(16'h5555, 1'b1, 1'b1, 1'b0, 1'b1)};

    // Reset and idle with activity on the cell inputs.
    #2;
    now_expect("reset", 5'b00000);
    @(posedge K); #1;
    RN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      IN = 8'($urandom); CE = 2'b11; SR = 2'($urandom);
      step_expect("idle", 5'b00000);
    end
    IN = 8'h00; CE = 2'b00; SR = 2'b00;

    // Combinational LUT on cell 0.
    send_cfg(cfg_a, 40, 5'b10000);
    IN = 8'hF1; now_expect("lut_f1", 5'b10100);
    IN = 8'h03; now_expect("lut_03", 5'b10000);
    IN = 8'h08; now_expect("lut_08", 5'b10100);
    IN = 8'h02; now_expect("lut_02", 5'b10100);
    IN = 8'h00; now_expect("lut_00", 5'b10000);

    // Clear from ACTIVE, then abort a partial load (clear beats enable).
    CFG_CLR = 1'b1; CFG_EN = 1'b1;
    step_expect("clr_active", 5'b00000);
    CFG_CLR = 1'b0; CFG_EN = 1'b0;
    send_cfg(cfg_b, 25, 5'b00000);
    CFG_CLR = 1'b1; CFG_EN = 1'b1;
    step_expect("abort", 5'b00000);
    CFG_CLR = 1'b0; CFG_EN = 1'b0;
    IN = 8'hA5;
    now_expect("abort_comb", 5'b00000);
    step_expect("abort_idle", 5'b00000);
    IN = 8'h00;

    // Full reload; CE/SR asserted during load must not matter on the entry edge.
    CE = 2'b11; SR = 2'b11;
    send_cfg(cfg_b, 40, 5'b10101);
    SR = 2'b00; CE = 2'b01;

    // Feedback toggle on cell 0.
    step_expect("toggle0", 5'b10000);
    step_expect("toggle1", 5'b10101);
    step_expect("toggle2", 5'b10000);
    step_expect("toggle3", 5'b10101);

    // SR beats CE; then hold.
    SR = 2'b01; CE = 2'b01;
    step_expect("sr_pri", 5'b10000);
    SR = 2'b00; CE = 2'b00;
    step_expect("sr_hold0", 5'b10000);
    step_expect("sr_hold1", 5'b10000);
    SR = 2'b10;
    step_expect("sr_cell1", 5'b11010);
    SR = 2'b00; CE = 2'b11;
    step_expect("ce_both", 5'b11111);
    CE = 2'b00;

    // CFG_EN activity while ACTIVE must not disturb the configuration.
    for (int i = 0; i < 6; i++) begin
      CFG_EN = ~CFG_EN; CFG_DIN = 1'($urandom);
      step_expect("en_ignored", 5'b11111);
    end
    CFG_EN = 1'b0;
    CE = 2'b01;
    step_expect("cfg_kept0", 5'b11010);
    step_expect("cfg_kept1", 5'b11111);
    CE = 2'b00;

    // Asynchronous reset while ACTIVE with Q=11.
    #2;
    RN = 1'b0;
    now_expect("rst_async", 5'b00000);
    @(posedge K); #1;
    RN = 1'b1;
    CE = 2'b11;
    for (int i = 0; i < 4; i++) begin
      IN = 8'($urandom);
      step_expect("post_rst", 5'b00000);
    end

    check_val("sb_empty", 5'(exp_q.size()), 5'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clb_gen.md
CLB_GEN -- requirements
Module: clb_gen

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- LUT_K, 4, number of LUT inputs per cell (2..6).
- NCELL, 2, number of logic cells.
REQ-002 The block SHALL derive these values: CB = 2^LUT_K + 4 config bits per cell; CFG_LEN = NCELL*CB; CW = $clog2(CFG_LEN+1).
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 The block SHALL have these ports, one per line: name, direction, width, meaning.
- K, in, 1, clock, rising edge.
- RN, in, 1, asynchronous active-low reset.
- CFG_CLR, in, 1, synchronous return to unconfigured.
- CFG_EN, in, 1, config bit valid.
- CFG_DIN, in, 1, serial config bit.
- CFG_DONE, out, 1, high when configured (ACTIVE).
- IN, in, NCELL*LUT_K, cell i inputs at [i*LUT_K +: LUT_K].
- CE, in, NCELL, per-cell register enable.
- SR, in, NCELL, per-cell synchronous set/reset.
- X, out, NCELL, per-cell combinational output.
- Q, out, NCELL, per-cell register output.

Function
REQ-005 The config store SHALL be a CFG_LEN-bit right-shift register: on each accepted bit, CFG_DIN enters bit CFG_LEN-1 and all bits shift down one, so the first bit sent ends at bit 0.
REQ-006 Cell i's config field SHALL be [i*CB +: CB], laid out as follows:
- LUT table at [0 +: 2^LUT_K].
- OUTSEL at 2^LUT_K.
- FBSEL at 2^LUT_K+1.
- SRVAL at 2^LUT_K+2.
- INIT at 2^LUT_K+3.
REQ-007 The FSM SHALL have three states: UNCONF, LOAD and ACTIVE. A bit counter cnt, CW bits wide, SHALL count accepted config bits.
REQ-008 In UNCONF, CFG_EN=1 SHALL shift one bit, set cnt=1 and move to LOAD.
REQ-009 In LOAD, CFG_EN=1 SHALL shift one bit and increment cnt. The accepted bit that makes cnt=CFG_LEN SHALL cause a move to ACTIVE on that same edge. CFG_EN=0 SHALL hold all state.
REQ-010 CFG_CLR=1 SHALL, in any state, set cnt=0 and state=UNCONF on the next edge; CFG_CLR SHALL take priority over CFG_EN. Shift register contents SHALL be kept.
REQ-011 In ACTIVE, CFG_EN SHALL be ignored.
REQ-012 CFG_DONE SHALL be 1 exactly when state=ACTIVE, with no combinational path from inputs.
REQ-013 The LUT address for cell i SHALL be IN[i*LUT_K +: LUT_K], except that bit 0 is replaced by Q[i] when FBSEL=1. F[i] SHALL be LUT[address].
REQ-014 On the edge that enters ACTIVE, Q[i] SHALL be loaded with INIT of cell i, using the complete config including the bit shifted on that edge. CE and SR SHALL be ignored on that edge.
REQ-015 In ACTIVE, each edge SHALL update each cell with this priority:
- SR[i]=1: Q[i] <= SRVAL.
- else CE[i]=1: Q[i] <= F[i].
- else Q[i] holds.
REQ-016 In ACTIVE, X[i] SHALL be Q[i] when OUTSEL=1 and F[i] when OUTSEL=0.
REQ-017 Outside ACTIVE, X and Q SHALL be 0 and CE/SR SHALL be ignored. Leaving ACTIVE via CFG_CLR SHALL clear Q on that edge.
REQ-018 Cells SHALL be independent; no cell SHALL depend on another cell's config or inputs.

Reset
REQ-019 RN=0 SHALL immediately force the following, regardless of K:
- state=UNCONF, cnt=0, shift register all 0.
- Q=0, X=0, CFG_DONE=0.
REQ-020 The block SHALL leave reset on the first K edge with RN=1. Reset asserted mid-LOAD or in ACTIVE SHALL discard the configuration, so a full reload is required.

Verification (LUT_K=4, NCELL=2, CB=20, CFG_LEN=40)
REQ-021 The bench SHALL cover these directed scenarios:
- Reset: pulse RN low -> CFG_DONE=0, X=00, Q=00; with RN=1, 10 idle cycles -> outputs unchanged.
- Combinational LUT: load cell0 LUT=16'h0116, OUTSEL=0, FBSEL=0; cell1 all 0 -> CFG_DONE rises on the edge accepting bit 40; IN[3:0]=4'h1 -> X[0]=1; 4'h3 -> X[0]=0; 4'h8 -> X[0]=1.
- Feedback toggle: cell0 LUT=16'h5555, FBSEL=1, OUTSEL=1, INIT=1, CE[0]=1 -> Q[0] reads 1 after done, then 0,1,0,... on successive edges, with X[0]=Q[0].
- SR priority: cell0 SRVAL=0, CE=1, SR=1 for 1 cycle while Q[0]=1 -> Q[0]=0 next edge; SR=0, CE=0 -> Q[0] holds 0.
- Config abort: CFG_CLR after 25 bits -> CFG_DONE stays 0 and X=00; send a fresh 40 bits -> CFG_DONE=1 only after bit 40; CFG_EN pulses while ACTIVE -> config unchanged.
- Reset mid-operation: RN low while ACTIVE with Q=11 -> Q, X and CFG_DONE go 0 without a clock edge; after release, IN activity gives X=00 until reload.
